// File: rtl/gcm64_pkg.sv
// Shared definitions for the 64-bit GCM datapath: FSM states, block width and
// reduction polynomial.
package gcm64_pkg;

    localparam int unsigned BLK_W = 64;
    localparam int unsigned CNT_W = 32;
    localparam logic [BLK_W-1:0] GCM64_POLY = 64'h000000000000001B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LEN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ghash_64_if.sv
// Control, block-stream handshake and tag bus of the GHASH core.
interface ghash_64_if;
    import gcm64_pkg::*;

    logic             h_load;
    logic [BLK_W-1:0] h_in;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             in_last;
    logic             tag_valid;
    logic [BLK_W-1:0] tag_out;
    logic             busy;

    // Source side: drives subkey, blocks and control strobes.
    modport master (
        output h_load, h_in, start, in_valid, in_data, in_last,
        input  in_ready, tag_valid, tag_out, busy
    );

    // Core side.
    modport slave (
        input  h_load, h_in, start, in_valid, in_data, in_last,
        output in_ready, tag_valid, tag_out, busy
    );

endinterface

// File: rtl/gf64_mul_step.sv
// One digit of the MSB-first GF(2^64) multiply: DIGIT rounds of
// Z = Z*x mod P, then Z ^= H when the multiplier bit is set.
module gf64_mul_step
    import gcm64_pkg::*;
#(
    parameter int unsigned      DIGIT = 1,
    parameter logic [BLK_W-1:0] POLY  = GCM64_POLY
) (
    input  logic [BLK_W-1:0] z,
    input  logic [BLK_W-1:0] h,
    input  logic [DIGIT-1:0] a,
    output logic [BLK_W-1:0] z_next
);

    // Unrolled shift/reduce/accumulate, highest multiplier bit first.
    always_comb begin
        z_next = z;
        for (int j = int'(DIGIT) - 1; j >= 0; j--) begin
            z_next = {z_next[BLK_W-2:0], 1'b0} ^ (z_next[BLK_W-1] ? POLY : '0);
            if (a[j]) begin
                z_next = z_next ^ h;
            end
        end
    end

endmodule

// File: rtl/ghash_64.sv
// GHASH over GF(2^64): Y_i = (Y_{i-1} ^ X_i) * H, digit-serial multiplier.
// Optional length block (bit length of the message) enabled by GHASH_LEN_BLOCK_EN.
module ghash_64
    import gcm64_pkg::*;
#(
    parameter int unsigned      DIGIT = 1,
    parameter logic [BLK_W-1:0] POLY  = GCM64_POLY
) (
    input  logic       clk,
    input  logic       reset,
    ghash_64_if.slave  bus
);

    localparam int unsigned STEP_W = 6;
    localparam int unsigned STEPS  = BLK_W / DIGIT;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t             state;
    state_t             state_next;
    logic [BLK_W-1:0]   y;
    logic [BLK_W-1:0]   h;
    logic [BLK_W-1:0]   hm;
    logic [BLK_W-1:0]   a;
    logic [BLK_W-1:0]   z;
    logic [BLK_W-1:0]   z_step;
    logic [BLK_W-1:0]   tag_q;
    logic               tag_valid_q;
    logic [CNT_W-1:0]   count;
    logic               last;
    logic [STEP_W-1:0]  step;
    logic               ready_c;
    logic               xfer_c;
    logic               mul_end_c;
    logic               mul_active_c;

    assign mul_active_c  = (state == MUL) || (state == LEN);
    assign bus.in_ready  = ready_c && !reset;
    assign bus.busy      = mul_active_c;
    assign bus.tag_valid = tag_valid_q;
    assign bus.tag_out   = tag_q;

    gf64_mul_step #(
        .DIGIT (DIGIT),
        .POLY  (POLY)
    ) u_step (
        .z      (z),
        .h      (hm),
        .a      (a[BLK_W-1 -: DIGIT]),
        .z_next (z_step)
    );

    // Next-state and handshake decode; start overrides everything.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        xfer_c     = 1'b0;
        mul_end_c  = 1'b0;
        case (state)
            IDLE: begin
                ready_c = !bus.start;
                xfer_c  = ready_c && bus.in_valid;
                if (xfer_c) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                mul_end_c = (step == LAST_STEP);
                if (mul_end_c) begin
                    if (!last) begin
                        state_next = IDLE;
                    end else begin
`ifdef GHASH_LEN_BLOCK_EN
                        state_next = LEN;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
`ifdef GHASH_LEN_BLOCK_EN
            LEN: begin
                mul_end_c = (step == LAST_STEP);
                if (mul_end_c) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.start) begin
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: subkey, accumulator, multiplier operands, block count and tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            y           <= '0;
            h           <= '0;
            hm          <= '0;
            a           <= '0;
            z           <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            count       <= '0;
            last        <= 1'b0;
            step        <= '0;
        end else begin
            tag_valid_q <= 1'b0;
            // New subkey only in IDLE; the multiply just launched keeps the old one.
            if ((state == IDLE) && bus.h_load) begin
                h <= bus.h_in;
            end
            if (bus.start) begin
                y     <= '0;
                count <= '0;
                last  <= 1'b0;
                step  <= '0;
                tag_q <= '0;
            end else if (xfer_c) begin
                a     <= y ^ bus.in_data;
                z     <= '0;
                hm    <= h;
                step  <= '0;
                last  <= bus.in_last;
                count <= count + CNT_W'(1);
            end else if (mul_active_c) begin
                z    <= z_step;
                a    <= a << DIGIT;
                step <= step + STEP_W'(1);
                if (mul_end_c) begin
                    y    <= z_step;
                    step <= '0;
                    if (state_next == DONE) begin
                        tag_q       <= z_step;
                        tag_valid_q <= 1'b1;
                    end
`ifdef GHASH_LEN_BLOCK_EN
                    if (state_next == LEN) begin
                        a <= z_step ^ {32'h0, CNT_W'(count << 6)};
                        z <= '0;
                    end
`endif
                end
            end
        end
    end

endmodule
